// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx_ascii receiver.
// Defining UART_RX_PARITY_EN adds the PARITY state to the state type.
package uart_rx_pkg;

   localparam int MIN_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   function automatic int cnt_width(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/uart_rx_ascii_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line appears idle coming out of reset.
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ascii.sv
// UART 8-N-1 receiver with a valid/ready byte output and one-cycle error pulses.
// Defining UART_RX_PARITY_EN switches the frame to 8-E-1 and enables parity_err.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | half-bit wait, then confirm the start bit is still low
//   DATA   | sample 8 data bits LSB first, one per bit period
//   PARITY | sample the even-parity bit (UART_RX_PARITY_EN only)
//   STOP   | sample the stop bit, then deliver, flag or drop the byte
module uart_rx_ascii
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       parity_err
);

   localparam int              CW      = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0]   HALF_LD = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0]   FULL_LD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cfg
      $error("uart_rx_ascii: CLKS_PER_BIT must be even and >= %0d", MIN_CLKS_PER_BIT);
   end

   logic rx_s;
   logic rx_s_dly_q;
   logic rx_fall;

   rx_state_e     state_q,   state_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q,   shift_d;
   logic [7:0]    data_q,    data_d;
   logic          valid_q,   valid_d;
   logic          ferr_q,    ferr_d;
   logic          oerr_q,    oerr_d;
   logic          cnt_tc;
`ifdef UART_RX_PARITY_EN
   logic          par_pend_q, par_pend_d;
   logic          perr_q,     perr_d;
`endif

   rx_sync u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   assign rx_fall = rx_s_dly_q & ~rx_s;
   assign cnt_tc  = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q & ~data_ready;
      ferr_d    = 1'b0;
      oerr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_d = par_pend_q;
      perr_d     = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d = ST_START;
               cnt_d   = HALF_LD;
`ifdef UART_RX_PARITY_EN
               par_pend_d = 1'b0;
`endif
            end
         end
         ST_START: begin
            if (cnt_tc) begin
               if (!rx_s) begin
                  state_d   = ST_DATA;
                  cnt_d     = FULL_LD;
                  bit_cnt_d = 3'd7;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DATA: begin
            if (cnt_tc) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = FULL_LD;
               if (bit_cnt_q == '0) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_tc) begin
               par_pend_d = rx_s ^ (^shift_q);
               cnt_d      = FULL_LD;
               state_d    = ST_STOP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_tc) begin
               state_d = ST_IDLE;
               if (!rx_s) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_pend_q) begin
                  perr_d = 1'b1;
`endif
               end else if (!valid_q || data_ready) begin
                  // a handshake in the same cycle frees the register for the new byte
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  oerr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s_dly_q <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         oerr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_s_dly_q <= rx_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         oerr_q     <= oerr_d;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= par_pend_d;
         perr_q     <= perr_d;
`endif
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign framing_err = ferr_q;
   assign overrun_err = oerr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = perr_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Bench for uart_rx_ascii: directed frame table, multi-frame corner sequences
// and a randomized run against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_ascii;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int LAT = 3 + C / 2 + 9 * C + (PAR_EN ? C : 0);
   localparam int FB  = PAR_EN ? 11 : 10;
   localparam int K_OK = 0, K_FERR = 1, K_PERR = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       framing_err;
   logic       overrun_err;
   logic       parity_err;

   uart_rx_ascii #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .framing_err (framing_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      bit         stop;
      bit         par_bad;
      bit         ready;
      bit         exp_valid;
      bit         exp_ferr;
      bit         exp_perr;
   } vec_t;

   typedef struct {
      int         e;
      int         kind;
      logic [7:0] d;
   } ev_t;

   vec_t       tbl[8];
   ev_t        evq[$];
   bit         line_q[$];
   logic [7:0] last_good = 8'h00;
   int         t0;
   bit         drv_done, sb_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [3:0] flags();
      return {data_valid, framing_err, overrun_err, parity_err};
   endfunction

   function automatic int ref_kind(input bit stop, input bit par_bad);
      if (!stop) return K_FERR;
      if (PAR_EN && par_bad) return K_PERR;
      return K_OK;
   endfunction

   function automatic void add_frame(input logic [7:0] d, input bit stop, input bit par_bad);
      line_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
      if (PAR_EN) line_q.push_back((^d) ^ par_bad);
      line_q.push_back(stop);
   endfunction

   // Called just after a rising edge; holds each bit for C cycles.
   task automatic drive_line();
      while (line_q.size() != 0) begin
         rx = line_q.pop_front();
         repeat (C) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic wait_edge(input int n);
      if (edge_cnt > n) begin
         errors++;
         $display("FAIL wait_edge: now at edge %0d, wanted %0d", edge_cnt, n);
      end
      while (edge_cnt < n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_valid();
      data_ready = 1'b1;
      idle(1);
      data_ready = 1'b0;
      idle(4);
   endtask

   // Two frames sent with no gap; returns after the second completes.
   task automatic two_frames(input bit pulse_ready);
      int e2;
      clear_valid();
      data_ready = 1'b0;
      add_frame(8'h41, 1'b1, 1'b0);
      add_frame(8'h42, 1'b1, 1'b0);
      t0 = edge_cnt + 1;
      e2 = t0 + FB * C + LAT;
      fork
         drive_line();
         begin
            wait_edge(t0 + LAT);
            check("b2b_first", {data_out, flags()}, {8'h41, 4'b1000});
            wait_edge(e2 - 1);
            check("b2b_hold", {data_out, flags()}, {8'h41, 4'b1000});
            if (pulse_ready) data_ready = 1'b1;
            wait_edge(e2);
            data_ready = 1'b0;
            if (pulse_ready) check("b2b_accept", {data_out, flags()}, {8'h42, 4'b1000});
            else             check("b2b_overrun", {data_out, flags()}, {8'h41, 4'b1010});
            wait_edge(e2 + 1);
            check("b2b_after", {data_out, flags()}, {pulse_ready ? 8'h42 : 8'h41, 4'b1000});
         end
      join
      last_good = pulse_ready ? 8'h42 : 8'h41;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] exp_d;
      bit         bad;

      tbl[0] = '{8'h61, 1'b1, 1'b0, 1'b1, 1'b1,    1'b0, 1'b0};
      tbl[1] = '{8'h7A, 1'b0, 1'b0, 1'b1, 1'b0,    1'b1, 1'b0};
      tbl[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1,    1'b0, 1'b0};
      tbl[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1,    1'b0, 1'b0};
      tbl[4] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0,    1'b1, 1'b0};
      tbl[5] = '{8'h03, 1'b1, 1'b1, 1'b1, !PAR_EN, 1'b0, PAR_EN};
      tbl[6] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1'b0,    1'b1, 1'b0};
      tbl[7] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1,    1'b0, 1'b0};

      rst_n = 1'b0;
      rx = 1'b1;
      data_ready = 1'b0;
      idle(3);
      check("reset_in", {data_out, flags()}, 12'h000);
      rst_n = 1'b1;
      idle(3);
      check("reset_out", {data_out, flags()}, 12'h000);

      for (int i = 0; i < 8; i++) begin
         clear_valid();
         data_ready = tbl[i].ready;
         add_frame(tbl[i].d, tbl[i].stop, tbl[i].par_bad);
         t0 = edge_cnt + 1;
         fork
            drive_line();
            begin
               wait_edge(t0 + LAT - 1);
               check("tbl_pre", flags(), 4'b0000);
               wait_edge(t0 + LAT);
               check("tbl_flags", flags(),
                     {tbl[i].exp_valid, tbl[i].exp_ferr, 1'b0, tbl[i].exp_perr});
               exp_d = tbl[i].exp_valid ? tbl[i].d : last_good;
               check("tbl_data", data_out, exp_d);
               last_good = exp_d;
               wait_edge(t0 + LAT + 1);
               check("tbl_after", flags(), {tbl[i].exp_valid & ~tbl[i].ready, 3'b000});
            end
         join
      end

      clear_valid();
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      bad = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (flags() != 4'b0000) bad = 1'b1;
      end
      check("glitch_quiet", bad, 1'b0);
      idle(1);
      add_frame(8'h55, 1'b1, 1'b0);
      t0 = edge_cnt + 1;
      fork
         drive_line();
         begin
            wait_edge(t0 + LAT - 1);
            check("glitch_next_pre", flags(), 4'b0000);
            wait_edge(t0 + LAT);
            check("glitch_next", {data_out, flags()}, {8'h55, 4'b1000});
         end
      join
      last_good = 8'h55;

      two_frames(1'b0);
      two_frames(1'b1);

      add_frame(8'h99, 1'b1, 1'b0);
      t0 = edge_cnt + 1;
      fork
         drive_line();
         begin
            wait_edge(t0 + 40);
            rst_n = 1'b0;
            #1;
            check("rst_async", {data_out, flags()}, 12'h000);
         end
      join
      idle(1);
      rst_n = 1'b1;
      last_good = 8'h00;
      idle(4);
      add_frame(8'h3C, 1'b1, 1'b0);
      t0 = edge_cnt + 1;
      fork
         drive_line();
         begin
            wait_edge(t0 + LAT - 1);
            check("rst_next_pre", {data_out, flags()}, 12'h000);
            wait_edge(t0 + LAT);
            check("rst_next", {data_out, flags()}, {8'h3C, 4'b1000});
         end
      join
      last_good = 8'h3C;

      clear_valid();
      drv_done = 1'b0;
      sb_done  = 1'b0;
      fork
         begin : rand_drv
            logic [7:0] d;
            bit         stop, pb;
            int         gap;
            for (int k = 0; k < 30; k++) begin
               d    = 8'($urandom_range(0, 255));
               stop = ($urandom_range(0, 5) != 0);
               pb   = ($urandom_range(0, 5) == 0);
               gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
               t0   = edge_cnt + 1;
               evq.push_back('{t0 + LAT, ref_kind(stop, pb), d});
               add_frame(d, stop, pb);
               drive_line();
               if (gap > 0) idle(gap);
            end
            drv_done = 1'b1;
         end
         begin : rand_ready
            while (!sb_done) begin
               @(posedge clk);
               #1;
               data_ready = ($urandom_range(0, 1) == 1);
            end
         end
         begin : scoreboard
            bit         m_valid, ready_prev, hs, load, ef, eo, ep;
            logic [7:0] m_data;
            ev_t        ev;
            m_valid = 1'b0;
            m_data  = last_good;
            @(negedge clk);
            ready_prev = data_ready;
            while (!(drv_done && evq.size() == 0)) begin
               @(negedge clk);
               hs = m_valid & ready_prev;
               load = 1'b0; ef = 1'b0; eo = 1'b0; ep = 1'b0;
               if (evq.size() != 0 && evq[0].e <= edge_cnt) begin
                  ev = evq.pop_front();
                  if (ev.kind == K_FERR)      ef = 1'b1;
                  else if (ev.kind == K_PERR) ep = 1'b1;
                  else if (!m_valid || hs) begin
                     load   = 1'b1;
                     m_data = ev.d;
                  end else eo = 1'b1;
               end
               if (load)    m_valid = 1'b1;
               else if (hs) m_valid = 1'b0;
               check("rand", {data_out, flags()}, {m_data, m_valid, ef, eo, ep});
               ready_prev = data_ready;
            end
            last_good = m_data;
            sb_done = 1'b1;
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
